// File: rtl/poly_op_scheduler.sv
// Round-robin command scheduler for the shared polynomial operation unit:
// grants two requesters, sequences start/done with a watchdog, returns tagged responses.
module poly_op_scheduler #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         cmd_valid,
    output logic [1:0]         cmd_ready,
    input  logic [5:0]         cmd_mode,
    input  logic [3:0]         cmd_enc,
    input  logic [2*TAG_W-1:0] cmd_tag,
    output logic               op_start,
    output logic [2:0]         op_mode,
    output logic [1:0]         op_encode_mode,
    output logic               op_rst,
    input  logic               op_done,
    output logic               op_owner,
    output logic               busy,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_BUSY,
        S_ABORT,
        S_RESP
    } state_t;

    state_t             state, state_next;
    logic               last_grant;
    logic [TAG_W-1:0]   tag_q;
    logic               err_q;
    logic [CNT_W-1:0]   wd_cnt;

    logic               grant;
    logic               any_valid;
    logic               accept;
    logic [2:0]         sel_mode;
    logic [1:0]         sel_enc;
    logic [TAG_W-1:0]   sel_tag;

    // On contention the requester that did not win last time goes first.
    assign any_valid = |cmd_valid;
    assign grant     = (cmd_valid == 2'b11) ? ~last_grant : cmd_valid[1];
    assign sel_mode  = grant ? cmd_mode[5:3] : cmd_mode[2:0];
    assign sel_enc   = grant ? cmd_enc[3:2]  : cmd_enc[1:0];
    assign sel_tag   = grant ? cmd_tag[2*TAG_W-1:TAG_W] : cmd_tag[TAG_W-1:0];
    assign accept    = (state == S_IDLE) && any_valid;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        cmd_ready  = 2'b00;
        op_start   = 1'b0;
        op_rst     = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_valid) begin
                    cmd_ready  = grant ? 2'b10 : 2'b01;
                    state_next = (sel_mode > 3'd4) ? S_RESP : S_SETUP;
                end
            end
            S_SETUP: state_next = S_ISSUE;
            S_ISSUE: begin
                op_start   = 1'b1;
                state_next = S_BUSY;
            end
            S_BUSY: begin
                // A done on the timeout cycle still counts as a normal completion.
                if (op_done)
                    state_next = S_RESP;
                else if (wd_cnt == CNT_W'(TIMEOUT - 1))
                    state_next = S_ABORT;
            end
            S_ABORT: begin
                op_rst     = 1'b1;
                state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            last_grant     <= 1'b1;
            op_mode        <= 3'd0;
            op_encode_mode <= 2'd0;
            op_owner       <= 1'b0;
            tag_q          <= '0;
            err_q          <= 1'b0;
            wd_cnt         <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_mode        <= sel_mode;
                op_encode_mode <= sel_enc;
                op_owner       <= grant;
                last_grant     <= grant;
                tag_q          <= sel_tag;
                err_q          <= (sel_mode > 3'd4);
            end
            if (state == S_ISSUE)
                wd_cnt <= '0;
            else if (state == S_BUSY)
                wd_cnt <= wd_cnt + 1'b1;
            if (state == S_ABORT)
                err_q <= 1'b1;
        end
    end

    // Response fields are gated so they read zero outside the response cycle.
    assign busy    = (state != S_IDLE);
    assign rsp_id  = rsp_valid & op_owner;
    assign rsp_tag = rsp_valid ? tag_q : '0;
    assign rsp_err = rsp_valid & err_q;

endmodule

// File: tb/tb_poly_op_scheduler.sv
// Self-checking bench for poly_op_scheduler: directed scenarios plus randomized
// two-requester traffic checked against a transaction-level expectation model.
module tb_poly_op_scheduler;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         cmd_valid;
    logic [1:0]         cmd_ready;
    logic [5:0]         cmd_mode;
    logic [3:0]         cmd_enc;
    logic [2*TAG_W-1:0] cmd_tag;
    logic               op_start;
    logic [2:0]         op_mode;
    logic [1:0]         op_encode_mode;
    logic               op_rst;
    logic               op_done;
    logic               op_owner;
    logic               busy;
    logic               rsp_valid;
    logic               rsp_id;
    logic [TAG_W-1:0]   rsp_tag;
    logic               rsp_err;

    always #5 clk = ~clk;

    poly_op_scheduler #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_enc(cmd_enc), .cmd_tag(cmd_tag),
        .op_start(op_start), .op_mode(op_mode), .op_encode_mode(op_encode_mode),
        .op_rst(op_rst), .op_done(op_done), .op_owner(op_owner), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Pending command per requester, held until granted (valid/ready semantics).
    bit               pend_v[2];
    logic [2:0]       pend_mode[2];
    logic [1:0]       pend_enc[2];
    logic [TAG_W-1:0] pend_tag[2];
    int               model_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_cmd();
        cmd_valid = {pend_v[1], pend_v[0]};
        cmd_mode  = {pend_mode[1], pend_mode[0]};
        cmd_enc   = {pend_enc[1], pend_enc[0]};
        cmd_tag   = {pend_tag[1], pend_tag[0]};
    endtask

    // Advance one cycle, apply inputs just after the edge, then let outputs settle.
    task automatic step(input logic done);
        @(posedge clk);
        #1;
        op_done = done;
        drive_cmd();
        #1;
    endtask

    task automatic set_cmd(input int r, input logic [2:0] m, input logic [1:0] e,
                           input logic [TAG_W-1:0] t);
        pend_v[r]    = 1'b1;
        pend_mode[r] = m;
        pend_enc[r]  = e;
        pend_tag[r]  = t;
    endtask

    // One full transaction from the IDLE cycle in which it is accepted.
    // lat: BUSY cycle (1-based after op_start) on which op_done arrives; 0 = never.
    task automatic do_txn(input int lat, input bit stray);
        int               g;
        logic [2:0]       m;
        logic [1:0]       e;
        logic [TAG_W-1:0] t;
        bit               done_seen;
        drive_cmd();
        #1;
        if (pend_v[0] && pend_v[1]) g = 1 - model_last;
        else                        g = pend_v[1] ? 1 : 0;
        check("grant_ready", cmd_ready, 32'(1 << g));
        check("idle_busy", busy, 0);
        m = pend_mode[g];
        e = pend_enc[g];
        t = pend_tag[g];
        pend_v[g]  = 1'b0;
        model_last = g;

        step(stray);
        check("owner", op_owner, g);
        check("ready_low", cmd_ready, 0);
        if (m > 3'd4) begin
            check("inv_rsp_valid", rsp_valid, 1);
            check("inv_rsp_id", rsp_id, g);
            check("inv_rsp_tag", rsp_tag, t);
            check("inv_rsp_err", rsp_err, 1);
            check("inv_no_start", op_start, 0);
            step(1'b0);
            check("inv_back_idle", busy, 0);
            return;
        end
        check("setup_mode", op_mode, m);
        check("setup_enc", op_encode_mode, e);
        check("setup_no_start", op_start, 0);

        step(1'b0);
        check("issue_start", op_start, 1);
        check("issue_mode", op_mode, m);
        check("issue_busy", busy, 1);

        done_seen = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            step(k == lat);
            check("busy_quiet", {op_start, op_rst, rsp_valid}, 0);
            if (k == lat) begin
                done_seen = 1'b1;
                break;
            end
        end

        step(1'b0);
        if (done_seen) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_no_abort", op_rst, 0);
            check("rsp_err0", rsp_err, 0);
        end else begin
            check("abort_rst", op_rst, 1);
            check("abort_no_rsp", rsp_valid, 0);
            step(1'b0);
            check("to_rsp_valid", rsp_valid, 1);
            check("to_rsp_err", rsp_err, 1);
            check("to_rst_single", op_rst, 0);
        end
        check("rsp_id", rsp_id, g);
        check("rsp_tag", rsp_tag, t);
        check("rsp_mode_held", op_mode, m);

        step(1'b0);
        check("back_idle", busy, 0);
        check("idle_mode_held", op_mode, m);
        check("idle_owner_held", op_owner, g);
    endtask

    initial begin
        rst        = 1'b1;
        op_done    = 1'b0;
        model_last = 1;
        for (int r = 0; r < 2; r++) begin
            pend_v[r] = 1'b0; pend_mode[r] = '0; pend_enc[r] = '0; pend_tag[r] = '0;
        end
        drive_cmd();
        #12;
        check("reset_outputs",
              {cmd_ready, op_start, op_mode, op_encode_mode, op_rst, op_owner,
               busy, rsp_valid, rsp_id, rsp_tag, rsp_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0);

        // Contention straight after reset: req0 first, then req1.
        set_cmd(0, 3'd0, 2'd0, 4'd1);
        set_cmd(1, 3'd2, 2'd1, 4'd2);
        do_txn(5, 1'b0);
        do_txn(7, 1'b0);

        // Single ADD on req0 with tag 5.
        set_cmd(0, 3'd3, 2'd1, 4'd5);
        do_txn(10, 1'b0);

        // Invalid mode on req1.
        set_cmd(1, 3'd6, 2'd0, 4'd9);
        do_txn(3, 1'b0);

        // Watchdog expiry, then a normal command, then done exactly on the boundary.
        set_cmd(0, 3'd1, 2'd2, 4'd3);
        do_txn(0, 1'b0);
        set_cmd(1, 3'd4, 2'd3, 4'd4);
        do_txn(2, 1'b1);
        set_cmd(0, 3'd2, 2'd0, 4'd6);
        do_txn(TIMEOUT, 1'b0);

        // Randomized traffic; often both requesters are waiting.
        for (int n = 0; n < 60; n++) begin
            int lat_sel;
            int lat;
            for (int r = 0; r < 2; r++)
                if (!pend_v[r] && $urandom_range(0, 3) != 0)
                    set_cmd(r, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                            TAG_W'($urandom));
            if (!pend_v[0] && !pend_v[1])
                set_cmd($urandom_range(0, 1), 3'($urandom_range(0, 4)), 2'd0,
                        TAG_W'($urandom));
            lat_sel = $urandom_range(0, 9);
            if (lat_sel == 0)      lat = 0;
            else if (lat_sel == 1) lat = TIMEOUT;
            else                   lat = $urandom_range(1, TIMEOUT - 1);
            do_txn(lat, $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of BUSY, followed by a stray done.
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        set_cmd(0, 3'd2, 2'd1, 4'd11);
        drive_cmd();
        #1;
        pend_v[0] = 1'b0;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check("pre_reset_busy", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_outputs",
              {cmd_ready, op_start, op_mode, op_encode_mode, op_rst, op_owner,
               busy, rsp_valid, rsp_id, rsp_tag, rsp_err}, 0);
        @(negedge clk);
        rst        = 1'b0;
        model_last = 1;
        step(1'b1);
        check("stray_done_idle", {busy, rsp_valid, op_start}, 0);
        step(1'b0);
        check("stray_done_quiet", {busy, rsp_valid, op_rst}, 0);

        // Contention again after reset: req0 must win.
        set_cmd(0, 3'd3, 2'd0, 4'd12);
        set_cmd(1, 3'd0, 2'd2, 4'd13);
        do_txn(4, 1'b0);
        do_txn(6, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
